// File: rtl/game_fsm.sv
// Pong game-flow controller: synchronizes the start button, tracks both scores from the
// ball position, sequences START/PLAY/POINT/GAME_OVER and flags the winner.
module game_fsm #(
    parameter int unsigned HOR_PIXELS  = 1024,
    parameter int unsigned BALL_SIZE   = 15,
    parameter int unsigned GOAL_MARGIN = 8,
    parameter int unsigned WIN_SCORE   = 5,
    parameter int unsigned PAUSE_TICKS = 60
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_timing_tick,
    input  logic        i_start_btn,
    input  logic [10:0] i_x_ball,
    output logic [1:0]  o_state,
    output logic [3:0]  o_score_left,
    output logic [3:0]  o_score_right,
    output logic        o_goal_pulse,
    output logic        o_winner_left
);

    localparam logic [1:0] ST_START     = 2'd0;
    localparam logic [1:0] ST_PLAY      = 2'd1;
    localparam logic [1:0] ST_POINT     = 2'd2;
    localparam logic [1:0] ST_GAME_OVER = 2'd3;

    localparam int unsigned PAUSE_W = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_TICKS - 1);
    localparam logic [10:0] LEFT_ZONE  = 11'(GOAL_MARGIN);
    localparam logic [10:0] RIGHT_ZONE = 11'(HOR_PIXELS - BALL_SIZE - GOAL_MARGIN);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

    logic [1:0]         r_state;
    logic [3:0]         r_score_left;
    logic [3:0]         r_score_right;
    logic               r_goal_pulse;
    logic               r_winner_left;
    logic [PAUSE_W-1:0] r_pause_cnt;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync_prev;

    logic [1:0]         w_state_next;
    logic [3:0]         w_score_left_next;
    logic [3:0]         w_score_right_next;
    logic               w_goal_pulse_next;
    logic               w_winner_left_next;
    logic [PAUSE_W-1:0] w_pause_cnt_next;
    logic               w_press;
    logic               w_goal_left;
    logic               w_goal_right;
    logic [3:0]         w_inc_left;
    logic [3:0]         w_inc_right;

    always_comb begin
        w_press      = r_sync2 & ~r_sync_prev;
        // Ball at the left wall is a point for the right player, and vice versa.
        w_goal_right = i_timing_tick && (i_x_ball <= LEFT_ZONE);
        w_goal_left  = i_timing_tick && (i_x_ball >= RIGHT_ZONE);
        w_inc_left   = r_score_left + 4'd1;
        w_inc_right  = r_score_right + 4'd1;

        w_state_next       = r_state;
        w_score_left_next  = r_score_left;
        w_score_right_next = r_score_right;
        w_goal_pulse_next  = 1'b0;
        w_winner_left_next = r_winner_left;
        w_pause_cnt_next   = r_pause_cnt;

        case (r_state)
            ST_START: begin
                if (w_press) begin
                    w_state_next       = ST_PLAY;
                    w_score_left_next  = 4'd0;
                    w_score_right_next = 4'd0;
                    w_winner_left_next = 1'b0;
                end
            end
            ST_PLAY: begin
                // A press coinciding with a goal tick is simply not looked at here.
                if (w_goal_left) begin
                    w_score_left_next = w_inc_left;
                    w_goal_pulse_next = 1'b1;
                    w_pause_cnt_next  = '0;
                    if (w_inc_left == WIN) begin
                        w_state_next       = ST_GAME_OVER;
                        w_winner_left_next = 1'b1;
                    end else begin
                        w_state_next = ST_POINT;
                    end
                end else if (w_goal_right) begin
                    w_score_right_next = w_inc_right;
                    w_goal_pulse_next  = 1'b1;
                    w_pause_cnt_next   = '0;
                    if (w_inc_right == WIN) begin
                        w_state_next       = ST_GAME_OVER;
                        w_winner_left_next = 1'b0;
                    end else begin
                        w_state_next = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (i_timing_tick) begin
                    if (r_pause_cnt == PAUSE_LAST) begin
                        w_state_next     = ST_PLAY;
                        w_pause_cnt_next = '0;
                    end else begin
                        w_pause_cnt_next = r_pause_cnt + 1'b1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (w_press) begin
                    w_state_next = ST_START;
                end
            end
            default: w_state_next = ST_START;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_START;
            r_score_left  <= 4'd0;
            r_score_right <= 4'd0;
            r_goal_pulse  <= 1'b0;
            r_winner_left <= 1'b0;
            r_pause_cnt   <= '0;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync_prev   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_score_left  <= w_score_left_next;
            r_score_right <= w_score_right_next;
            r_goal_pulse  <= w_goal_pulse_next;
            r_winner_left <= w_winner_left_next;
            r_pause_cnt   <= w_pause_cnt_next;
            r_sync1       <= i_start_btn;
            r_sync2       <= r_sync1;
            r_sync_prev   <= r_sync2;
        end
    end

    assign o_state       = r_state;
    assign o_score_left  = r_score_left;
    assign o_score_right = r_score_right;
    assign o_goal_pulse  = r_goal_pulse;
    assign o_winner_left = r_winner_left;

endmodule

// File: tb/tb_game_fsm.sv
// Directed, table-driven bench for game_fsm at default parameters.
module tb_game_fsm;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        start;
    logic [10:0] x_ball;
    logic [1:0]  state;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        pulse;
    logic        win_l;

    int n_checks;
    int n_pass;

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_POINT = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    typedef struct {
        logic        tick;
        logic [10:0] x;
        logic [1:0]  st;
        int          sl;
        int          sr;
        logic        pulse;
    } vec_t;

    vec_t vecs[16];

    game_fsm dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_timing_tick (tick),
        .i_start_btn   (start),
        .i_x_ball      (x_ball),
        .o_state       (state),
        .o_score_left  (score_l),
        .o_score_right (score_r),
        .o_goal_pulse  (pulse),
        .o_winner_left (win_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sits out the post-goal pause; a start press is thrown in and must be ignored.
    task automatic run_pause(input int sl, input int sr);
        step();
        chk("pulse_one_cycle", pulse, 0);
        chk("point_hold", state, S_POINT);
        for (int k = 1; k <= 60; k++) begin
            tick   = 1'b1;
            x_ball = 11'd0;
            start  = (k >= 2 && k <= 5);
            step();
            tick = 1'b0;
            chk("pause_state", state, (k < 60) ? S_POINT : S_PLAY);
            step();
        end
        start = 1'b0;
        chk("pause_score_l", score_l, sl);
        chk("pause_score_r", score_r, sr);
        chk("pause_no_pulse", pulse, 0);
    endtask

    task automatic apply_vec(input int i);
        tick   = vecs[i].tick;
        x_ball = vecs[i].x;
        step();
        tick = 1'b0;
        chk($sformatf("vec%0d_state", i), state, vecs[i].st);
        chk($sformatf("vec%0d_score_l", i), score_l, vecs[i].sl);
        chk($sformatf("vec%0d_score_r", i), score_r, vecs[i].sr);
        chk($sformatf("vec%0d_pulse", i), pulse, vecs[i].pulse);
        if (vecs[i].st == S_POINT) run_pause(vecs[i].sl, vecs[i].sr);
    endtask

    task automatic press_to(input logic [1:0] from_st, input logic [1:0] to_st);
        start = 1'b1;
        step();
        chk("press_edge1", state, from_st);
        step();
        chk("press_edge2", state, from_st);
        step();
        chk("press_edge3", state, to_st);
        start = 1'b0;
        for (int k = 0; k < 3; k++) step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        tick     = 1'b0;
        start    = 1'b0;
        x_ball   = 11'd500;

        vecs[0]  = '{1'b0, 11'd8,    S_PLAY,  0, 0, 1'b0};
        vecs[1]  = '{1'b1, 11'd500,  S_PLAY,  0, 0, 1'b0};
        vecs[2]  = '{1'b1, 11'd9,    S_PLAY,  0, 0, 1'b0};
        vecs[3]  = '{1'b1, 11'd1000, S_PLAY,  0, 0, 1'b0};
        vecs[4]  = '{1'b1, 11'd8,    S_POINT, 0, 1, 1'b1};
        vecs[5]  = '{1'b0, 11'd1001, S_PLAY,  0, 1, 1'b0};
        vecs[6]  = '{1'b0, 11'd1001, S_PLAY,  0, 1, 1'b0};
        vecs[7]  = '{1'b0, 11'd1001, S_PLAY,  0, 1, 1'b0};
        vecs[8]  = '{1'b0, 11'd1001, S_PLAY,  0, 1, 1'b0};
        vecs[9]  = '{1'b0, 11'd1001, S_PLAY,  0, 1, 1'b0};
        vecs[10] = '{1'b1, 11'd1001, S_POINT, 1, 1, 1'b1};
        vecs[11] = '{1'b1, 11'd0,    S_POINT, 1, 2, 1'b1};
        vecs[12] = '{1'b1, 11'd2047, S_POINT, 2, 2, 1'b1};
        vecs[13] = '{1'b1, 11'd1500, S_POINT, 4, 2, 1'b1};
        vecs[14] = '{1'b1, 11'd1001, S_OVER,  5, 2, 1'b1};
        vecs[15] = '{1'b1, 11'd8,    S_POINT, 0, 1, 1'b1};

        #12;
        chk("rst_state", state, S_START);
        chk("rst_score_l", score_l, 0);
        chk("rst_score_r", score_r, 0);
        chk("rst_pulse", pulse, 0);
        chk("rst_winner", win_l, 0);
        #5 rst_n = 1'b1;
        step();
        step();

        // Button held for 10 cycles: one transition on the 3rd edge.
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("start_edge%0d", k), state, (k < 3) ? S_START : S_PLAY);
        end
        start = 1'b0;
        chk("start_score_l", score_l, 0);
        chk("start_score_r", score_r, 0);
        for (int k = 0; k < 3; k++) step();

        for (int i = 0; i <= 12; i++) apply_vec(i);

        // Press edge and goal tick land in the same PLAY cycle: goal wins.
        start = 1'b1;
        step();
        step();
        tick   = 1'b1;
        x_ball = 11'd1001;
        step();
        tick = 1'b0;
        chk("coinc_state", state, S_POINT);
        chk("coinc_score_l", score_l, 3);
        chk("coinc_pulse", pulse, 1);
        start = 1'b0;
        run_pause(3, 2);

        apply_vec(13);
        apply_vec(14);
        chk("over_winner", win_l, 1);
        step();
        chk("over_pulse_clear", pulse, 0);
        tick   = 1'b1;
        x_ball = 11'd8;
        step();
        tick = 1'b0;
        chk("over_no_score_r", score_r, 2);
        chk("over_hold", state, S_OVER);

        press_to(S_OVER, S_START);
        chk("start_keeps_l", score_l, 5);
        chk("start_keeps_r", score_r, 2);
        press_to(S_START, S_PLAY);
        chk("play_clear_l", score_l, 0);
        chk("play_clear_r", score_r, 0);

        // Goal, then asynchronous reset between edges while pulse is high.
        tick   = vecs[15].tick;
        x_ball = vecs[15].x;
        step();
        tick = 1'b0;
        chk("pre_rst_state", state, vecs[15].st);
        chk("pre_rst_pulse", pulse, vecs[15].pulse);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, S_START);
        chk("async_rst_score_r", score_r, 0);
        chk("async_rst_pulse", pulse, 0);
        step();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick   = 1'b1;
            x_ball = 11'd0;
            step();
            chk("post_rst_pulse", pulse, 0);
            chk("post_rst_state", state, S_START);
        end
        tick = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
